ufp_write_merge: RTL
====================

# ufp_write_merge

Write-merge line buffer on the upstream-facing (UFP) store path of the data cache. It absorbs 32-bit byte-masked stores into one 256-bit line image, then writes that line to the downstream port (DFP) in a single 256-bit transaction with a 32-bit byte mask. A write-back happens on a tag conflict, on an explicit flush, or (optionally) after an idle timeout. It performs the word-to-line packing that the read path undoes when it selects a word out of a line.

## Interface
- FLUSH_IDLE, 16: idle cycles in VALID before automatic write-back (only with idle flush compiled in); legal 1..255
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous and active-high
- ufp_addr  in  32  store byte address; [31:5] tag, [4:2] word index, [1:0] ignored
- ufp_wmask  in  4  byte enables for ufp_wdata
- ufp_wdata  in  32  store data
- ufp_write  in  1  store request; held with addr/wmask/wdata stable until ufp_resp
- ufp_resp  out  1  one-cycle pulse, store absorbed
- flush  in  1  level request to drain the buffer; held until flush_done
- flush_done  out  1  one-cycle pulse, buffer empty
- dfp_addr  out  32  {tag, 5'b0}
- dfp_wdata  out  256  line image, word i at [32i+31:32i]
- dfp_bmask  out  32  byte-valid mask, bit b covers dfp_wdata[8b+7:8b]
- dfp_write  out  1  line write request, held until dfp_resp
- dfp_resp  in  1  one-cycle downstream acknowledge

## Operation
- States: EMPTY, VALID, WB. Reset -> EMPTY. Line data, tag, byte-valid and idle counter cleared. All outputs 0.
- Merge: for each set ufp_wmask[k], byte 4*idx+k of the line takes ufp_wdata[8k+7:8k], and its byte-valid bit is set. Other bytes are unchanged.
- EMPTY + ufp_write: load the tag, merge, pulse ufp_resp, go to VALID.
- VALID + ufp_write, tag equal: merge, pulse ufp_resp, clear the idle counter.
- VALID + ufp_write, tag differs: go to WB and do not respond. After dfp_resp, return to EMPTY. The held request is then accepted as in EMPTY.
- VALID + flush (no ufp_write): go to WB. After dfp_resp, go to EMPTY and pulse flush_done.
- EMPTY + flush: pulse flush_done the next cycle. No DFP traffic.
- flush and ufp_write in the same cycle: the store is handled first and flush stays pending. The flush is serviced in the following cycles.
- Byte-valid all zero (only zero-wmask stores absorbed): a write-back skips DFP and goes straight to EMPTY. flush_done or the pending accept follows with the same timing as the EMPTY case.
- ufp_wmask = 0: acknowledged normally with no data or mask change. It still allocates the tag when in EMPTY.
- In WB, dfp_addr, dfp_wdata and dfp_bmask are stable and dfp_write = 1 until dfp_resp. A new ufp_write is not accepted in WB.

## Timing
- Hit or EMPTY accept: ufp_write sampled at edge N. ufp_resp = 1 during cycle N+1, registered.
- A ufp_write high in the same cycle as ufp_resp is a new request, so back-to-back stores run at 1 store per cycle.
- Conflict: dfp_write rises the cycle after the conflicting request is sampled. dfp_resp is sampled at edge M, giving EMPTY in M+1. The pending store is sampled at M+1 and ufp_resp is high in M+2.
- Flush from VALID: with dfp_resp at edge M, flush_done is high in M+1.
- dfp_write deasserts in the cycle after dfp_resp. dfp_resp outside WB is ignored.
- Reset mid-WB: dfp_write drops asynchronously. Buffered data and any pending store are discarded.

## Configuration
- UFP_WMERGE_IDLE_FLUSH_EN defined:
  - An 8-bit idle counter increments each VALID cycle with no ufp_write and no flush. It clears on accept.
  - Reaching FLUSH_IDLE starts WB. The write-back ends in EMPTY with no flush_done.
  - An idle-triggered WB blocks ufp_write exactly like a conflict WB.
- Not defined: no counter. The line leaves only on conflict or flush, and FLUSH_IDLE is unused.

## Test plan
- Reset, then store addr 0x1000_0004, wmask 0xF, data 0xDEADBEEF -> ufp_resp next cycle. Flush -> dfp_addr 0x1000_0000, dfp_wdata[63:32] = 0xDEADBEEF, dfp_bmask = 0x0000_00F0, then flush_done the cycle after dfp_resp.
- Byte merge: stores to 0x20 wmask 0x1 data 0x11, then wmask 0x8 data 0x4400_0000 -> flush gives word0 = 0x4400_0011, bmask = 0x9.
- Conflict: store to 0x40, then store to 0x80 -> dfp_write with dfp_addr 0x40, second ufp_resp 2 cycles after dfp_resp. A later flush writes dfp_addr 0x80.
- Zero-mask store then flush -> no dfp_write, flush_done one cycle after flush is sampled.
- With UFP_WMERGE_IDLE_FLUSH_EN and FLUSH_IDLE = 4: one store, then idle -> dfp_write rises 4 cycles after ufp_resp and no flush_done. Without the macro, no dfp_write over 100 idle cycles.
- Assert rst while dfp_write is high -> dfp_write is 0 in the same cycle and a subsequent flush gives flush_done with no dfp_write.

Source files
------------

// File: rtl/ufp_write_merge_if.sv
// ufp_write_merge_if: UFP store port, flush handshake and DFP line-write port of the write-merge buffer.
interface ufp_write_merge_if;
  logic [31:0]  ufp_addr;
  logic [3:0]   ufp_wmask;
  logic [31:0]  ufp_wdata;
  logic         ufp_write;
  logic         ufp_resp;
  logic         flush;
  logic         flush_done;
  logic [31:0]  dfp_addr;
  logic [255:0] dfp_wdata;
  logic [31:0]  dfp_bmask;
  logic         dfp_write;
  logic         dfp_resp;
  modport slave (
    input  ufp_addr, ufp_wmask, ufp_wdata, ufp_write, flush, dfp_resp,
    output ufp_resp, flush_done, dfp_addr, dfp_wdata, dfp_bmask, dfp_write
  );
  modport master (
    output ufp_addr, ufp_wmask, ufp_wdata, ufp_write, flush, dfp_resp,
    input  ufp_resp, flush_done, dfp_addr, dfp_wdata, dfp_bmask, dfp_write
  );
endinterface

// File: rtl/ufp_write_merge.sv
// ufp_write_merge: merges byte-masked word stores into one line, written back on conflict, flush
// or, with UFP_WMERGE_IDLE_FLUSH_EN defined, after FLUSH_IDLE idle cycles.
module ufp_write_merge #(
  parameter int FLUSH_IDLE = 16
) (
  input logic clk,
  input logic rst,
  ufp_write_merge_if.slave u
);
  typedef enum logic [1:0] {EMPTY, VALID, WB} state_t;
  state_t state, nstate;
  logic [26:0] tag;
  logic [7:0][3:0][7:0] data, mdata;
  logic [7:0][3:0] bmask, mmask;
  logic live, hit, accept, wb_go, wb_end, fdone, wbf, idle_hit;
  logic unused;
  assign unused = ^u.ufp_addr[1:0];
  // a line holding no valid bytes behaves exactly like an empty buffer
  assign live = state == VALID && |bmask;
  assign hit = u.ufp_addr[31:5] == tag;
  assign u.dfp_write = state == WB;
  assign u.dfp_addr = {tag, 5'b0};
  assign u.dfp_wdata = data;
  assign u.dfp_bmask = bmask;
  always_comb begin
    mdata = live ? data : '0;
    mmask = live ? bmask : '0;
    for (int k = 0; k < 4; k++)
      if (u.ufp_wmask[k]) begin
        mdata[u.ufp_addr[4:2]][k] = u.ufp_wdata[8*k +: 8];
        mmask[u.ufp_addr[4:2]][k] = 1'b1;
      end
  end
  always_comb begin
    nstate = state;
    accept = 1'b0;
    wb_go = 1'b0;
    wb_end = 1'b0;
    fdone = 1'b0;
    if (state == WB) begin
      wb_end = u.dfp_resp;
      nstate = u.dfp_resp ? EMPTY : WB;
    end else if (u.ufp_write) begin
      accept = !live || hit;
      wb_go = !accept;
      nstate = accept ? VALID : WB;
    end else if (u.flush || idle_hit) begin
      wb_go = live;
      fdone = u.flush && !live;
      nstate = live ? WB : EMPTY;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= EMPTY;
    else state <= nstate;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tag <= '0;
      data <= '0;
      bmask <= '0;
      wbf <= 1'b0;
      u.ufp_resp <= 1'b0;
      u.flush_done <= 1'b0;
    end else begin
      u.ufp_resp <= accept;
      u.flush_done <= fdone || (wb_end && wbf);
      if (wb_go) wbf <= u.flush && !u.ufp_write;
      if (accept) begin
        tag <= u.ufp_addr[31:5];
        data <= mdata;
        bmask <= mmask;
      end else if (wb_end) begin
        tag <= '0;
        data <= '0;
        bmask <= '0;
      end
    end
`ifdef UFP_WMERGE_IDLE_FLUSH_EN
  logic [7:0] idle;
  always_ff @(posedge clk or posedge rst)
    if (rst) idle <= '0;
    else idle <= (live && !u.ufp_write && !u.flush) ? idle + 8'd1 : '0;
  assign idle_hit = live && (9'(idle) + 9'd1 >= 9'(FLUSH_IDLE));
`else
  assign idle_hit = 1'b0 & (FLUSH_IDLE != 0);
`endif
endmodule
